// File: rtl/operand_entry.sv
// Operand entry for a two-operand calculator front end.
// Buttons edit one hex nibble at a time of operand A, then operand B; the pair
// is then offered downstream (valid) until ack returns the FSM to EDIT_A.
module operand_entry #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = WIDTH / 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      btn_up,
   input  logic                      btn_down,
   input  logic                      btn_left,
   input  logic                      btn_right,
   input  logic                      btn_enter,
   input  logic                      clr,
   input  logic                      ack,
   output logic [WIDTH-1:0]          operand_a,
   output logic [WIDTH-1:0]          operand_b,
   output logic [$clog2(DIGITS)-1:0] digit_sel,
   output logic                      edit_b,
   output logic                      valid
);

   localparam int SELW = $clog2(DIGITS);

   typedef enum logic [1:0] {
      EDIT_A = 2'd0,
      EDIT_B = 2'd1,
      OFFER  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [SELW-1:0]   sel_q, sel_d;

   logic [WIDTH-1:0]  active;
   logic [WIDTH-1:0]  edited;
   logic [3:0]        nib;
   logic [SELW-1:0]   sel_moved;

   // Nibble edit and digit move of the operand being edited (pre-move digit_sel)
   always_comb begin
      active    = (state_q == EDIT_B) ? b_q : a_q;
      edited    = active;
      nib       = '0;
      sel_moved = sel_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (SELW'(i) == sel_q) begin
            nib = active[i*4 +: 4];
            if (btn_up && !btn_down)
               nib = nib + 4'd1;
            else if (btn_down && !btn_up)
               nib = nib - 4'd1;
            edited[i*4 +: 4] = nib;
         end
      end
      // DIGITS need not be a power of two, so wrap explicitly
      if (btn_left && !btn_right)
         sel_moved = (sel_q == SELW'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
      else if (btn_right && !btn_left)
         sel_moved = (sel_q == '0) ? SELW'(DIGITS - 1) : sel_q - 1'b1;
   end

   // Next-state: enter beats clr, clr beats nibble edit + digit move
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      case (state_q)
         EDIT_A, EDIT_B: begin
            if (btn_enter) begin
               state_d = (state_q == EDIT_A) ? EDIT_B : OFFER;
               sel_d   = '0;
            end else if (clr) begin
               if (state_q == EDIT_B) b_d = '0;
               else                   a_d = '0;
               sel_d = '0;
            end else begin
               if (state_q == EDIT_B) b_d = edited;
               else                   a_d = edited;
               sel_d = sel_moved;
            end
         end
         OFFER: begin
            if (ack) state_d = EDIT_A;
         end
         default: state_d = EDIT_A;
      endcase
   end

   // State and operand registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EDIT_A;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
      end
   end

   assign operand_a = a_q;
   assign operand_b = b_q;
   assign digit_sel = sel_q;
   assign edit_b    = (state_q == EDIT_B);
   assign valid     = (state_q == OFFER);

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: the stimulus pushes hand-computed
// expectations, a separate monitor pops and compares against the outputs.
module tb_operand_entry;

   localparam int W = 16;

   localparam int unsigned U = 1, D = 2, L = 4, R = 8, E = 16, C = 32, K = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
   logic          btn_right = 1'b0, btn_enter = 1'b0, clr = 1'b0, ack = 1'b0;
   logic [W-1:0]  operand_a, operand_b;
   logic [1:0]    digit_sel;
   logic          edit_b, valid;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   sel;
      logic         eb;
      logic         v;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   operand_entry #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_enter (btn_enter),
      .clr       (clr),
      .ack       (ack),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .digit_sel (digit_sel),
      .edit_b    (edit_b),
      .valid     (valid)
   );

   always #5 clk = ~clk;

   task automatic push(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] sel, input logic eb, input logic v);
      exp_t e;
      e.name = n; e.a = a; e.b = b; e.sel = sel; e.eb = eb; e.v = v;
      sb.push_back(e);
   endtask

   // One-cycle pulse on the selected inputs, driven from the falling edge
   task automatic pulse(input int unsigned m);
      @(negedge clk);
      btn_up    = (m & U) != 0;
      btn_down  = (m & D) != 0;
      btn_left  = (m & L) != 0;
      btn_right = (m & R) != 0;
      btn_enter = (m & E) != 0;
      clr       = (m & C) != 0;
      ack       = (m & K) != 0;
      @(posedge clk);
      #1;
      {btn_up, btn_down, btn_left, btn_right, btn_enter, clr, ack} = '0;
   endtask

   // Monitor: compares shortly after every clock edge or reset assertion
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         #2;
         while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (operand_a !== e.a || operand_b !== e.b || digit_sel !== e.sel ||
                edit_b !== e.eb || valid !== e.v) begin
               errors++;
               $display("FAIL %s: got a=%h b=%h sel=%0d eb=%b v=%b, want a=%h b=%h sel=%0d eb=%b v=%b",
                        e.name, operand_a, operand_b, digit_sel, edit_b, valid,
                        e.a, e.b, e.sel, e.eb, e.v);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 push("reset_hold", 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // three increments of nibble 0
      pulse(U); push("up1", 16'h0001, 16'h0000, 2'd0, 1'b0, 1'b0);
      pulse(U); push("up2", 16'h0002, 16'h0000, 2'd0, 1'b0, 1'b0);
      pulse(U); push("up3", 16'h0003, 16'h0000, 2'd0, 1'b0, 1'b0);

      // decrement wrap, right wrap, upper nibble
      pulse(C); push("clr_a", 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);
      pulse(D); push("down_wrap", 16'h000F, 16'h0000, 2'd0, 1'b0, 1'b0);
      pulse(R); push("right_wrap", 16'h000F, 16'h0000, 2'd3, 1'b0, 1'b0);
      pulse(U); push("up_msn", 16'h100F, 16'h0000, 2'd3, 1'b0, 1'b0);
      pulse(L); push("left_wrap", 16'h100F, 16'h0000, 2'd0, 1'b0, 1'b0);
      pulse(U); push("up_nocarry", 16'h1000, 16'h0000, 2'd0, 1'b0, 1'b0);
      pulse(D); push("down_noborrow", 16'h100F, 16'h0000, 2'd0, 1'b0, 1'b0);

      // simultaneous events
      pulse(U | D); push("up_and_down", 16'h100F, 16'h0000, 2'd0, 1'b0, 1'b0);
      pulse(L | R); push("left_and_right", 16'h100F, 16'h0000, 2'd0, 1'b0, 1'b0);
      pulse(U | L); push("up_with_left", 16'h1000, 16'h0000, 2'd1, 1'b0, 1'b0);
      pulse(C | U | L); push("clr_beats_up", 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);

      // enter A = 0x00A0
      pulse(L); push("sel1", 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         pulse(U);
         push("build_a", 16'((i + 1) << 4), 16'h0000, 2'd1, 1'b0, 1'b0);
      end
      pulse(E | U); push("enter_with_up", 16'h00A0, 16'h0000, 2'd0, 1'b1, 1'b0);

      // enter B = 0x0005
      for (int i = 0; i < 5; i++) begin
         pulse(U);
         push("build_b", 16'h00A0, 16'(i + 1), 2'd0, 1'b1, 1'b0);
      end
      pulse(E); push("offer", 16'h00A0, 16'h0005, 2'd0, 1'b0, 1'b1);

      // buttons ignored while offering
      pulse(U); push("offer_up", 16'h00A0, 16'h0005, 2'd0, 1'b0, 1'b1);
      pulse(D | R); push("offer_down_right", 16'h00A0, 16'h0005, 2'd0, 1'b0, 1'b1);
      pulse(L); push("offer_left", 16'h00A0, 16'h0005, 2'd0, 1'b0, 1'b1);
      pulse(C); push("offer_clr", 16'h00A0, 16'h0005, 2'd0, 1'b0, 1'b1);
      pulse(E); push("offer_enter", 16'h00A0, 16'h0005, 2'd0, 1'b0, 1'b1);
      pulse(K); push("ack", 16'h00A0, 16'h0005, 2'd0, 1'b0, 1'b0);
      pulse(K); push("ack_ignored", 16'h00A0, 16'h0005, 2'd0, 1'b0, 1'b0);

      // B = 0x1234 then clr in EDIT_B
      pulse(E); push("to_b", 16'h00A0, 16'h0005, 2'd0, 1'b1, 1'b0);
      pulse(D); push("b_d0", 16'h00A0, 16'h0004, 2'd0, 1'b1, 1'b0);
      pulse(L);
      for (int i = 0; i < 3; i++) pulse(U);
      push("b_d1", 16'h00A0, 16'h0034, 2'd1, 1'b1, 1'b0);
      pulse(L);
      for (int i = 0; i < 2; i++) pulse(U);
      push("b_d2", 16'h00A0, 16'h0234, 2'd2, 1'b1, 1'b0);
      pulse(L);
      pulse(U); push("b_1234", 16'h00A0, 16'h1234, 2'd3, 1'b1, 1'b0);
      pulse(C); push("clr_b", 16'h00A0, 16'h0000, 2'd0, 1'b1, 1'b0);

      // asynchronous reset mid-OFFER
      pulse(U); push("b_one", 16'h00A0, 16'h0001, 2'd0, 1'b1, 1'b0);
      pulse(E); push("offer2", 16'h00A0, 16'h0001, 2'd0, 1'b0, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      push("async_rst", 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      btn_up = 1'b1;
      @(posedge clk);
      #1 btn_up = 1'b0;
      push("first_edge", 16'h0001, 16'h0000, 2'd0, 1'b0, 1'b0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      #3;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
